// File: rtl/alu_core_pkg.sv
// Shared constants for the 6502-style ALU: data width, opcodes, status bit positions.
package alu_core_pkg;

  localparam int unsigned REG_WIDTH = 8;

  // Operation codes driven by the decoder; anything not listed behaves as NOP.
  localparam logic [7:0] ALU_NOP  = 8'h00;
  localparam logic [7:0] ALU_ADC  = 8'h01;
  localparam logic [7:0] ALU_SBC  = 8'h02;
  localparam logic [7:0] ALU_AND  = 8'h03;
  localparam logic [7:0] ALU_ORA  = 8'h04;
  localparam logic [7:0] ALU_EOR  = 8'h05;
  localparam logic [7:0] ALU_ASL  = 8'h06;
  localparam logic [7:0] ALU_LSR  = 8'h07;
  localparam logic [7:0] ALU_ROL  = 8'h08;
  localparam logic [7:0] ALU_ROR  = 8'h09;
  localparam logic [7:0] ALU_INC  = 8'h0A;
  localparam logic [7:0] ALU_DEC  = 8'h0B;
  localparam logic [7:0] ALU_CMP  = 8'h0C;
  localparam logic [7:0] ALU_BIT  = 8'h0D;
  localparam logic [7:0] ALU_PASS = 8'h0E;

  // Status register bit positions (bit 5 unused).
  localparam int unsigned CARRY = 0;
  localparam int unsigned ZERO  = 1;
  localparam int unsigned IRQ   = 2;
  localparam int unsigned DEC   = 3;
  localparam int unsigned BRK   = 4;
  localparam int unsigned OVER  = 6;
  localparam int unsigned NEG   = 7;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result and next status from func/a/b/status_in.
module alu_comb
  import alu_core_pkg::*;
(
  input  logic [7:0]           func,
  input  logic [7:0]           status_in,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] result,
  output logic [7:0]           next_status,
  output logic                 valid
);

  localparam logic [REG_WIDTH-1:0] One = {{(REG_WIDTH - 1){1'b0}}, 1'b1};

  logic                 c_in;
  logic [REG_WIDTH:0]   sum;
  logic [REG_WIDTH:0]   c_ext;

  assign c_in  = status_in[CARRY];
  assign c_ext = {{REG_WIDTH{1'b0}}, c_in};

  // Decode func and compute result plus flags; untouched flags (incl. I/D/B/bit 5) pass through.
  always_comb begin
    sum         = '0;
    result      = '0;
    next_status = status_in;
    valid       = 1'b1;
    case (func)
      ALU_ADC: begin
        sum                = {1'b0, a} + {1'b0, b} + c_ext;
        result             = sum[REG_WIDTH-1:0];
        next_status[CARRY] = sum[REG_WIDTH];
        next_status[OVER]  = ~(a[REG_WIDTH-1] ^ b[REG_WIDTH-1]) &
                             (a[REG_WIDTH-1] ^ result[REG_WIDTH-1]);
      end
      ALU_SBC: begin
        sum                = {1'b0, a} + {1'b0, ~b} + c_ext;
        result             = sum[REG_WIDTH-1:0];
        next_status[CARRY] = sum[REG_WIDTH];
        next_status[OVER]  = (a[REG_WIDTH-1] ^ b[REG_WIDTH-1]) &
                             (a[REG_WIDTH-1] ^ result[REG_WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_ORA: result = a | b;
      ALU_EOR: result = a ^ b;
      ALU_ASL: begin
        result             = {a[REG_WIDTH-2:0], 1'b0};
        next_status[CARRY] = a[REG_WIDTH-1];
      end
      ALU_LSR: begin
        result             = {1'b0, a[REG_WIDTH-1:1]};
        next_status[CARRY] = a[0];
      end
      ALU_ROL: begin
        result             = {a[REG_WIDTH-2:0], c_in};
        next_status[CARRY] = a[REG_WIDTH-1];
      end
      ALU_ROR: begin
        result             = {c_in, a[REG_WIDTH-1:1]};
        next_status[CARRY] = a[0];
      end
      ALU_INC: result = a + One;
      ALU_DEC: result = a - One;
      ALU_CMP: begin
        // a + ~b + 1: carry out is set exactly when a >= b unsigned.
        sum                = {1'b0, a} + {1'b0, ~b} + {{REG_WIDTH{1'b0}}, 1'b1};
        result             = sum[REG_WIDTH-1:0];
        next_status[CARRY] = sum[REG_WIDTH];
      end
      ALU_BIT: begin
        result            = a & b;
        next_status[OVER] = b[REG_WIDTH-2];
      end
      ALU_PASS: result = a;
      default: valid = 1'b0;
    endcase

    if (valid) begin
      next_status[ZERO] = (result == '0);
      // BIT reports the memory operand's top bit rather than the result's.
      next_status[NEG]  = (func == ALU_BIT) ? b[REG_WIDTH-1] : result[REG_WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: one operation per valid func cycle, with a one-cycle done pulse.
module alu_core
  import alu_core_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           func,
  input  logic [7:0]           status_in,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] dout,
  output logic                 wout,
  output logic [7:0]           status_out
);

  logic [REG_WIDTH-1:0] result;
  logic [7:0]           next_status;
  logic                 valid;

  alu_comb u_alu_comb (
    .func        (func),
    .status_in   (status_in),
    .a           (a),
    .b           (b),
    .result      (result),
    .next_status (next_status),
    .valid       (valid)
  );

  // Capture result/flags on valid ops; NOP holds them. Reset wins over any func.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout       <= '0;
      status_out <= '0;
      wout       <= 1'b0;
    end else begin
      wout <= valid;
      if (valid) begin
        dout       <= result;
        status_out <= next_status;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: table of vectors plus hand sequences, checked through a scoreboard queue.
module tb_alu_core;
  import alu_core_pkg::*;

  typedef struct {
    logic [7:0] func;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] st;
    logic [7:0] exp_d;
    logic [7:0] exp_s;
  } vec_t;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic [7:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] func;
  logic [7:0] status_in;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] dout;
  logic       wout;
  logic [7:0] status_out;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  vec_t vecs[$];
  logic [7:0] hold_d = 8'h00;
  logic [7:0] hold_s = 8'h00;

  alu_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .func       (func),
    .status_in  (status_in),
    .a          (a),
    .b          (b),
    .dout       (dout),
    .wout       (wout),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] f, input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] st, input logic [7:0] ed, input logic [7:0] es);
    vec_t v;
    v.func = f; v.a = va; v.b = vb; v.st = st; v.exp_d = ed; v.exp_s = es;
    return v;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, req);
  endtask

  // Compare DUT outputs against the oldest expectation, just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check8("wout", {7'b0, wout}, {7'b0, e.w});
      check8("dout", dout, e.d);
      check8("status_out", status_out, e.s);
    end
  end

  // Drive one cycle of stimulus and queue what the following edge should produce.
  task automatic apply(input logic rst_n, input logic [7:0] f, input logic [7:0] va,
                       input logic [7:0] vb, input logic [7:0] st, input logic op_valid,
                       input logic [7:0] ed, input logic [7:0] es);
    exp_t e;
    @(negedge clk);
    reset_n = rst_n; func = f; a = va; b = vb; status_in = st;
    if (!rst_n) begin
      hold_d = 8'h00; hold_s = 8'h00; e.w = 1'b0;
    end else if (op_valid) begin
      hold_d = ed; hold_s = es; e.w = 1'b1;
    end else begin
      e.w = 1'b0;
    end
    e.d = hold_d;
    e.s = hold_s;
    sb.push_back(e);
  endtask

  initial begin
    reset_n = 1'b1; func = ALU_NOP; a = 8'h00; b = 8'h00; status_in = 8'h00;

    //                 func      a      b      st     dout   status
    vecs.push_back(mk(ALU_ADC,  8'h50, 8'h50, 8'h1C, 8'hA0, 8'hDC));
    vecs.push_back(mk(ALU_ADC,  8'hFF, 8'h01, 8'h1C, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_ADC,  8'h01, 8'h01, 8'h1D, 8'h03, 8'h1C));
    vecs.push_back(mk(ALU_SBC,  8'h05, 8'h06, 8'h1D, 8'hFF, 8'h9C));
    vecs.push_back(mk(ALU_SBC,  8'h80, 8'h01, 8'h1D, 8'h7F, 8'h5D));
    vecs.push_back(mk(ALU_ASL,  8'h81, 8'h00, 8'h1C, 8'h02, 8'h1D));
    vecs.push_back(mk(ALU_LSR,  8'h01, 8'h00, 8'h1C, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_ROR,  8'h01, 8'h00, 8'h1D, 8'h80, 8'h9D));
    vecs.push_back(mk(ALU_ROL,  8'h80, 8'h00, 8'h1C, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_CMP,  8'h10, 8'h10, 8'h1C, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_CMP,  8'h05, 8'h10, 8'h5C, 8'hF5, 8'hDC));
    vecs.push_back(mk(ALU_BIT,  8'h01, 8'hC0, 8'h1C, 8'h00, 8'hDE));
    vecs.push_back(mk(ALU_INC,  8'hFF, 8'h00, 8'h1D, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_DEC,  8'h00, 8'h00, 8'h1C, 8'hFF, 8'h9C));
    vecs.push_back(mk(ALU_ORA,  8'h0F, 8'hF0, 8'h1C, 8'hFF, 8'h9C));
    vecs.push_back(mk(ALU_EOR,  8'hFF, 8'hFF, 8'h9C, 8'h00, 8'h1E));
    vecs.push_back(mk(ALU_PASS, 8'h00, 8'h00, 8'h9D, 8'h00, 8'h1F));
    vecs.push_back(mk(ALU_AND,  8'hF0, 8'h3C, 8'h3C, 8'h30, 8'h3C));

    // Reset with a valid op presented: the op must not complete.
    apply(1'b0, ALU_ADC, 8'h50, 8'h50, 8'h1C, 1'b1, 8'h00, 8'h00);
    // Release on NOP: outputs stay cleared, no pulse.
    apply(1'b1, ALU_NOP, 8'h12, 8'h34, 8'h1C, 1'b0, 8'h00, 8'h00);
    apply(1'b1, ALU_NOP, 8'h12, 8'h34, 8'h1C, 1'b0, 8'h00, 8'h00);

    // Table: applied back to back, so wout must stay high through the run.
    foreach (vecs[i])
      apply(1'b1, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].st, 1'b1,
            vecs[i].exp_d, vecs[i].exp_s);

    // Invalid code and NOP after an op: pulse drops, outputs hold the AND result.
    apply(1'b1, 8'h3F, 8'hAA, 8'h55, 8'hFF, 1'b0, 8'h00, 8'h00);
    apply(1'b1, ALU_NOP, 8'hAA, 8'h55, 8'hFF, 1'b0, 8'h00, 8'h00);

    // ADC then AND on consecutive cycles.
    apply(1'b1, ALU_ADC, 8'h50, 8'h50, 8'h1C, 1'b1, 8'hA0, 8'hDC);
    apply(1'b1, ALU_AND, 8'hA0, 8'h0F, 8'h1C, 1'b1, 8'h00, 8'h1E);

    // Reset arriving in the middle of a stream of valid ops.
    apply(1'b1, ALU_INC, 8'h41, 8'h00, 8'h1C, 1'b1, 8'h42, 8'h1C);
    apply(1'b0, ALU_INC, 8'h41, 8'h00, 8'h1C, 1'b1, 8'h00, 8'h00);
    apply(1'b1, ALU_NOP, 8'h00, 8'h00, 8'h1C, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 8-bit 6502-style arithmetic/logic unit with a registered result and status flags.
- Sits beside the data bus.
- Operands arrive from the bus ALU0/ALU1 outputs, and the operation code arrives from the decoder.
- Result returns to the bus, updated flags go to the STATUS register mux, and a one-cycle done pulse goes to the decoder.

Parameters:
- None. Data width is fixed by the shared package constant REG_WIDTH = 8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- func  in  8  operation code (package encoding).
- status_in  in  8  current processor status register.
- a  in  8  operand A (accumulator side / shift source).
- b  in  8  operand B (memory/immediate side).
- dout  out  8  registered result.
- wout  out  1  done pulse; result and flags valid.
- status_out  out  8  registered updated status.

Behaviour:
- Status bit positions: C=0, Z=1, I=2, D=3, B=4, unused=5, V=6, N=7.
  - D is ignored: binary arithmetic only.
  - I, D, B and bit 5 are always copied from status_in.
- func encoding:
  - 00 NOP, 01 ADC, 02 SBC, 03 AND, 04 ORA, 05 EOR, 06 ASL, 07 LSR
  - 08 ROL, 09 ROR, 0A INC, 0B DEC, 0C CMP, 0D BIT, 0E PASS
  - All other codes behave as NOP.
- Reset (reset_n low at rising edge):
  - dout=00, status_out=00, wout=0.
  - Reset has priority over any func; an operation presented in a reset cycle never completes.
- Latency and handshake:
  - At each rising edge with reset_n high and func valid (not NOP), compute from a, b, status_in sampled at that edge.
  - Register dout and status_out; assert wout for exactly that following cycle.
  - func held valid on consecutive cycles performs one operation per cycle, with wout high each cycle; no busy state.
  - NOP/invalid: wout=0; dout and status_out hold previous values.
- Flag update: flags not listed for an op are copied from status_in. N=r[7] and Z=(r==0) unless stated otherwise.
- Arithmetic:
  - ADC: r=a+b+C. C=carry out of bit 7. V=(~(a^b)&(a^r))[7]. N, Z.
  - SBC: r=a+~b+C. C=carry out (1 = no borrow). V=((a^b)&(a^r))[7]. N, Z.
- Logic:
  - AND/ORA/EOR: r=a op b. N, Z.
- Shifts (operand a only):
  - ASL: r={a[6:0],0}, C=a[7].
  - LSR: r={0,a[7:1]}, C=a[0], N=0.
  - ROL: r={a[6:0],C}, C=a[7].
  - ROR: r={C,a[7:1]}, C=a[0].
  - N, Z from r for all shifts.
- Increment/decrement (operand a only):
  - INC: r=a+1, wraps FF->00. N, Z; C unchanged.
  - DEC: r=a-1, wraps 00->FF. N, Z; C unchanged.
- Compare and bit test:
  - CMP: r=a-b (8-bit). C=(a>=b) unsigned. Z=(a==b). N=r[7]. V unchanged. dout=r; consumers must not write it back.
  - BIT: dout=a&b. Z=((a&b)==0). N=b[7]. V=b[6].
- PASS: dout=a. N, Z (transfer instructions).

Decomposition:
- Shared package holds REG_WIDTH, the func opcode constants (ALU_NOP..ALU_PASS), and the status bit indices (CARRY, ZERO, IRQ, DEC, BRK, OVER, NEG).
- One natural sub-module: alu_comb, a purely combinational compute of {result, next_status} from func/a/b/status_in.
- Top-level alu_core holds only the registers and the wout pulse.

Test Plan:
- Reset: reset_n=0 for one edge while func=ADC -> dout=00, status_out=00, wout=0 next cycle. Release with func=NOP -> outputs hold 00, wout stays 0.
- ADC overflow/carry:
  - a=50, b=50, C=0 -> dout=A0, N=1, V=1, C=0, Z=0, wout pulse one cycle.
  - a=FF, b=01, C=0 -> dout=00, C=1, Z=1, V=0.
- SBC borrow: a=05, b=06, C=1 -> dout=FF, C=0, N=1, V=0. Then a=80, b=01, C=1 -> dout=7F, V=1, C=1.
- Shifts/rotates:
  - ASL a=81 -> 02, C=1.
  - LSR a=01 -> 00, C=1, Z=1, N=0.
  - ROR a=01, C=1 -> 80, C=1, N=1.
  - ROL a=80, C=0 -> 00, C=1, Z=1.
- CMP/BIT/INC:
  - CMP 10 vs 10 -> Z=1, C=1, N=0.
  - CMP 05 vs 10 -> C=0, N=1.
  - BIT a=01, b=C0 -> Z=1, N=1, V=1.
  - INC FF -> 00, Z=1, C unchanged.
- Back-to-back and invalid codes:
  - ADC then AND on consecutive cycles -> wout high two cycles, correct sequential results.
  - func=3F -> wout=0, outputs unchanged.
  - I/D/B bits of status_in=1C pass through unchanged on every op.
